// File: rtl/mario_wavrom_arbiter.sv
// mario_wavrom_arbiter
//   Shares the single-port analogue wave ROM between the three sample voices
//   (0 = Mario run, 1 = Luigi run, 2 = skid). One read request is granted
//   per cycle and the ROM port is driven from that grant. The returned byte
//   is routed back to the voice that issued the read. While a ROM download
//   write is in progress, no new read is issued.
//
//   Build option: define WAVROM_FIXED_PRIO_EN to select fixed priority
//   (skid > Mario > Luigi). The default build uses round-robin arbitration.
//
// Ports
//   I_CLK_48M   in   1   system clock, rising edge
//   I_RESET     in   1   synchronous reset, active high
//   I_DLWR      in   1   ROM download write strobe, blocks new read issues
//   I_REQ       in   3   per-voice read request (level)
//   I_ADDR0..2  in   AW  per-voice read address
//   O_ACK       out  3   one-hot grant pulse
//   O_ROM_ADDR  out  AW  ROM read address
//   O_ROM_RD    out  1   ROM read enable
//   I_ROM_DATA  in   DW  ROM read data, ROM_LAT cycles after O_ROM_RD
//   O_DATA      out  DW  returned sample byte (holds when O_VALID = 0)
//   O_VALID     out  3   one-hot owner of O_DATA this cycle
//   O_BUSY      out  1   reads in flight
module mario_wavrom_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int ROM_LAT = 1
) (
  input  logic          I_CLK_48M,
  input  logic          I_RESET,
  input  logic          I_DLWR,
  input  logic [2:0]    I_REQ,
  input  logic [AW-1:0] I_ADDR0,
  input  logic [AW-1:0] I_ADDR1,
  input  logic [AW-1:0] I_ADDR2,
  output logic [2:0]    O_ACK,
  output logic [AW-1:0] O_ROM_ADDR,
  output logic          O_ROM_RD,
  input  logic [DW-1:0] I_ROM_DATA,
  output logic [DW-1:0] O_DATA,
  output logic [2:0]    O_VALID,
  output logic          O_BUSY
);

  logic [2:0]              ack_r;
  logic                    rd_r;
  logic [AW-1:0]           addr_r;
  logic [DW-1:0]           data_r;
  logic [2:0]              valid_r;
  logic                    busy_r;
  // Tag stage 0 runs alongside O_ROM_RD; stage ROM_LAT lines up with I_ROM_DATA.
  logic [ROM_LAT:0]        tag_vld_r;
  logic [ROM_LAT:0][1:0]   tag_id_r;

  logic [2:0]              eligible_s;
  logic                    grant_s;
  logic [1:0]              win_s;
  logic [AW-1:0]           win_addr_s;
  logic [ROM_LAT:0]        tag_vld_next_s;
  logic [ROM_LAT:0][1:0]   tag_id_next_s;

  // The voice just acked may still hold its request this cycle, so it is masked out.
  assign eligible_s = I_REQ & ~ack_r & {3{~I_DLWR}};

`ifdef WAVROM_FIXED_PRIO_EN
  // Fixed-priority winner selection: skid, then Mario, then Luigi.
  always_comb begin
    grant_s = 1'b0;
    win_s   = 2'd0;
    if (eligible_s[2]) begin
      grant_s = 1'b1;
      win_s   = 2'd2;
    end else if (eligible_s[0]) begin
      grant_s = 1'b1;
      win_s   = 2'd0;
    end else if (eligible_s[1]) begin
      grant_s = 1'b1;
      win_s   = 2'd1;
    end else begin
      grant_s = 1'b0;
      win_s   = 2'd0;
    end
  end
`else
  logic [1:0] ptr_r;
  logic [1:0] cand0_s;
  logic [1:0] cand1_s;

  function automatic logic [1:0] next_voice(input logic [1:0] id);
    case (id)
      2'd0:    next_voice = 2'd1;
      2'd1:    next_voice = 2'd2;
      2'd2:    next_voice = 2'd0;
      default: next_voice = 2'd0;
    endcase
  endfunction

  assign cand0_s = next_voice(ptr_r);
  assign cand1_s = next_voice(cand0_s);

  // Round-robin winner selection, starting at the voice after the last winner.
  always_comb begin
    grant_s = 1'b0;
    win_s   = 2'd0;
    if (eligible_s[cand0_s]) begin
      grant_s = 1'b1;
      win_s   = cand0_s;
    end else if (eligible_s[cand1_s]) begin
      grant_s = 1'b1;
      win_s   = cand1_s;
    end else if (eligible_s[ptr_r]) begin
      grant_s = 1'b1;
      win_s   = ptr_r;
    end else begin
      grant_s = 1'b0;
      win_s   = 2'd0;
    end
  end

  // Last-winner pointer; reset to 2 so voice 0 is searched first.
  always_ff @(posedge I_CLK_48M) begin
    if (I_RESET) begin
      ptr_r <= 2'd2;
    end else if (grant_s) begin
      ptr_r <= win_s;
    end
  end
`endif

  // Address of the winning voice.
  always_comb begin
    win_addr_s = I_ADDR0;
    case (win_s)
      2'd0:    win_addr_s = I_ADDR0;
      2'd1:    win_addr_s = I_ADDR1;
      2'd2:    win_addr_s = I_ADDR2;
      default: win_addr_s = I_ADDR0;
    endcase
  end

  // Next contents of the in-flight tag shift register.
  always_comb begin
    tag_vld_next_s = {tag_vld_r[ROM_LAT-1:0], grant_s};
    tag_id_next_s  = {tag_id_r[ROM_LAT-1:0], win_s};
  end

  // Grant, ROM port, tag pipeline and return-path registers.
  always_ff @(posedge I_CLK_48M) begin
    if (I_RESET) begin
      ack_r     <= 3'b000;
      rd_r      <= 1'b0;
      addr_r    <= {AW{1'b0}};
      tag_vld_r <= {(ROM_LAT+1){1'b0}};
      tag_id_r  <= {(2*(ROM_LAT+1)){1'b0}};
      data_r    <= {DW{1'b0}};
      valid_r   <= 3'b000;
      busy_r    <= 1'b0;
    end else begin
      ack_r     <= grant_s ? (3'b001 << win_s) : 3'b000;
      rd_r      <= grant_s;
      if (grant_s) begin
        addr_r <= win_addr_s;
      end
      tag_vld_r <= tag_vld_next_s;
      tag_id_r  <= tag_id_next_s;
      if (tag_vld_r[ROM_LAT]) begin
        data_r  <= I_ROM_DATA;
        valid_r <= 3'b001 << tag_id_r[ROM_LAT];
      end else begin
        valid_r <= 3'b000;
      end
      // Stage 0 valid equals O_ROM_RD, so this covers both.
      busy_r    <= |tag_vld_next_s;
    end
  end

  assign O_ACK      = ack_r;
  assign O_ROM_RD   = rd_r;
  assign O_ROM_ADDR = addr_r;
  assign O_DATA     = data_r;
  assign O_VALID    = valid_r;
  assign O_BUSY     = busy_r;

endmodule

// File: tb/tb_mario_wavrom_arbiter.sv
// tb_mario_wavrom_arbiter
//   Directed bench for mario_wavrom_arbiter with a one-cycle-latency ROM model.
module tb_mario_wavrom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dlwr = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [12:0] addr0 = 13'h0000;
  logic [12:0] addr1 = 13'h0000;
  logic [12:0] addr2 = 13'h0000;
  logic [2:0]  ack;
  logic [12:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  data;
  logic [2:0]  valid;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  mario_wavrom_arbiter #(.AW(13), .DW(8), .ROM_LAT(1)) dut (
    .I_CLK_48M (clk),
    .I_RESET   (rst),
    .I_DLWR    (dlwr),
    .I_REQ     (req),
    .I_ADDR0   (addr0),
    .I_ADDR1   (addr1),
    .I_ADDR2   (addr2),
    .O_ACK     (ack),
    .O_ROM_ADDR(rom_addr),
    .O_ROM_RD  (rom_rd),
    .I_ROM_DATA(rom_data),
    .O_DATA    (data),
    .O_VALID   (valid),
    .O_BUSY    (busy)
  );

  always #5 clk = ~clk;

  // ROM contents: 0xA5 at 0x0100, otherwise low address byte xor 0x3C.
  function automatic logic [7:0] rom_byte(input logic [12:0] a);
    if (a == 13'h0100) return 8'hA5;
    return a[7:0] ^ 8'h3C;
  endfunction

  // One-cycle read latency ROM.
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom_byte(rom_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 3'b000;
    dlwr = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  function automatic logic [12:0] rr_addr(input int v, input int n);
    return 13'h0010 + 13'(v * 16) + 13'(n);
  endfunction

  initial begin
    // Test 1: reset values, then a single read from voice 0.
    do_reset;
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_rd", 32'(rom_rd), 32'h0);
    check_eq("rst_addr", 32'(rom_addr), 32'h0);
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    req = 3'b001; addr0 = 13'h0100;
    tick;
    check_eq("t1_ack", 32'(ack), 32'h1);
    check_eq("t1_rd", 32'(rom_rd), 32'h1);
    check_eq("t1_addr", 32'(rom_addr), 32'h0100);
    check_eq("t1_busy", 32'(busy), 32'h1);
    req = 3'b000;
    tick;
    check_eq("t1_ack_off", 32'(ack), 32'h0);
    check_eq("t1_rd_off", 32'(rom_rd), 32'h0);
    check_eq("t1_busy2", 32'(busy), 32'h1);
    check_eq("t1_valid_early", 32'(valid), 32'h0);
    tick;
    check_eq("t1_valid", 32'(valid), 32'h1);
    check_eq("t1_data", 32'(data), 32'hA5);
    check_eq("t1_busy_end", 32'(busy), 32'h0);
    tick;
    check_eq("t1_valid_pulse", 32'(valid), 32'h0);
    check_eq("t1_data_hold", 32'(data), 32'hA5);

`ifndef WAVROM_FIXED_PRIO_EN
    // Test 2: all three voices requesting continuously, round-robin order.
    do_reset;
    req = 3'b111; addr0 = rr_addr(0, 0); addr1 = rr_addr(1, 0); addr2 = rr_addr(2, 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      check_eq("t2_ack", 32'(ack), 32'(3'b001 << (i % 3)));
      check_eq("t2_addr", 32'(rom_addr), 32'(rr_addr(i % 3, i / 3)));
      if (i >= 2) begin
        check_eq("t2_valid", 32'(valid), 32'(3'b001 << ((i - 2) % 3)));
        check_eq("t2_data", 32'(data), 32'(rom_byte(rr_addr((i - 2) % 3, (i - 2) / 3))));
      end
      if (ack[0]) addr0 = addr0 + 13'd1;
      if (ack[1]) addr1 = addr1 + 13'd1;
      if (ack[2]) addr2 = addr2 + 13'd1;
      if (i == 5) req = 3'b000;
    end
    for (int j = 4; j < 6; j++) begin
      tick;
      check_eq("t2_ack_idle", 32'(ack), 32'h0);
      check_eq("t2_valid_tail", 32'(valid), 32'(3'b001 << (j % 3)));
      check_eq("t2_data_tail", 32'(data), 32'(rom_byte(rr_addr(j % 3, j / 3))));
    end
`else
    // Fixed priority: skid and Mario alternate, Luigi starves.
    do_reset;
    req = 3'b111; addr0 = 13'h0010; addr1 = 13'h0020; addr2 = 13'h0030;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("fp_ack", 32'(ack), (i % 2 == 0) ? 32'h4 : 32'h1);
    end
    req = 3'b000;
    tick;
    tick;
`endif

    // Test 3: download write blocks issue; granted one cycle after it falls.
    dlwr = 1'b1; req = 3'b010; addr1 = 13'h0200;
    for (int k = 0; k < 5; k++) begin
      tick;
      check_eq("t3_ack_blk", 32'(ack), 32'h0);
      check_eq("t3_rd_blk", 32'(rom_rd), 32'h0);
    end
    dlwr = 1'b0;
    tick;
    check_eq("t3_ack", 32'(ack), 32'h2);
    check_eq("t3_addr", 32'(rom_addr), 32'h0200);
    req = 3'b000;
    tick;
    tick;
    check_eq("t3_valid", 32'(valid), 32'h2);
    check_eq("t3_data", 32'(data), 32'h3C);

    // Test 4: reset while two reads are in flight.
    req = 3'b011; addr0 = 13'h0300; addr1 = 13'h0301;
    tick;
    check_eq("t4_ack0", 32'(ack), 32'h1);
    req = 3'b010;
    tick;
    check_eq("t4_ack1", 32'(ack), 32'h2);
    rst = 1'b1; req = 3'b000;
    tick;
    check_eq("t4_rst_ack", 32'(ack), 32'h0);
    check_eq("t4_rst_rd", 32'(rom_rd), 32'h0);
    check_eq("t4_rst_addr", 32'(rom_addr), 32'h0);
    check_eq("t4_rst_valid", 32'(valid), 32'h0);
    check_eq("t4_rst_data", 32'(data), 32'h0);
    check_eq("t4_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick;
    check_eq("t4_valid_after", 32'(valid), 32'h0);
    check_eq("t4_busy_after", 32'(busy), 32'h0);
    req = 3'b111; addr0 = 13'h0355; addr1 = 13'h0356; addr2 = 13'h0357;
    tick;
    check_eq("t4_first", 32'(ack), 32'h1);
    req = 3'b110;
    tick;
    check_eq("t4_second", 32'(ack), 32'h2);
    req = 3'b100;
    tick;
    check_eq("t4_third", 32'(ack), 32'h4);
    check_eq("t4_valid0", 32'(valid), 32'h1);
    check_eq("t4_data0", 32'(data), 32'h69);
    req = 3'b000;
    tick;
    check_eq("t4_valid1", 32'(valid), 32'h2);
    check_eq("t4_data1", 32'(data), 32'h6A);
    tick;
    check_eq("t4_valid2", 32'(valid), 32'h4);
    check_eq("t4_data2", 32'(data), 32'h6B);

    // Test 5: request left high after its ack is not granted back-to-back.
    req = 3'b001; addr0 = 13'h0400;
    tick;
    check_eq("t5_ack_first", 32'(ack), 32'h1);
    tick;
    check_eq("t5_ack_gap", 32'(ack), 32'h0);
    check_eq("t5_rd_gap", 32'(rom_rd), 32'h0);
    tick;
    check_eq("t5_ack_again", 32'(ack), 32'h1);
    check_eq("t5_addr", 32'(rom_addr), 32'h0400);
    check_eq("t5_valid_first", 32'(valid), 32'h1);
    check_eq("t5_data_first", 32'(data), 32'h3C);
    req = 3'b000;
    tick;
    check_eq("t5_valid_gap", 32'(valid), 32'h0);
    tick;
    check_eq("t5_valid_second", 32'(valid), 32'h1);
    check_eq("t5_busy_end", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
